branch_resolve_bht: RTL and testbench

BRANCH_RESOLVE_BHT -- requirements
Module: branch_resolve_bht

---
 rtl/branch_resolve_bht_if.sv | 38 +++
 rtl/branch_resolve_bht.sv | 102 ++++++++++
 tb/tb_branch_resolve_bht.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_bht_if.sv
// Bundles the fetch-side lookup and the ID-side resolve/update signals of
// branch_resolve_bht.
//   slave  : the predictor (lookup/resolve inputs in, prediction/resolution out)
//   master : the pipeline driving it
// Signals: if_pc/if_pred_taken (lookup), id_valid/id_pc/id_op/id_rt/rsv/rtv/
// id_pred_taken (resolve inputs), is_branch/branch_taken/mispredict (resolve
// outputs), branch_cnt/mispred_cnt (statistics).
interface branch_resolve_bht_if #(
  parameter int DATA_W = 32,
  parameter int STAT_W = 32
);
  logic [31:0]       if_pc;
  logic              if_pred_taken;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [5:0]        id_op;
  logic [4:0]        id_rt;
  logic [DATA_W-1:0] rsv;
  logic [DATA_W-1:0] rtv;
  logic              id_pred_taken;
  logic              is_branch;
  logic              branch_taken;
  logic              mispredict;
  logic [STAT_W-1:0] branch_cnt;
  logic [STAT_W-1:0] mispred_cnt;

  modport slave (
    input  if_pc, id_valid, id_pc, id_op, id_rt, rsv, rtv, id_pred_taken,
    output if_pred_taken, is_branch, branch_taken, mispredict,
           branch_cnt, mispred_cnt
  );

  modport master (
    output if_pc, id_valid, id_pc, id_op, id_rt, rsv, rtv, id_pred_taken,
    input  if_pred_taken, is_branch, branch_taken, mispredict,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// Branch resolution in ID plus a bimodal branch history table (2-bit
// saturating counters) looked up at fetch.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (table -> weakly-not-taken, stats -> 0)
//   bus  : branch_resolve_bht_if.slave, lookup/resolve/statistics signals
module branch_resolve_bht #(
  parameter int DATA_W    = 32,
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH),
  parameter int STAT_W    = 32
) (
  input logic clk,
  input logic rst,
  branch_resolve_bht_if.slave bus
);

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  logic [1:0]        bht_q [BHT_DEPTH];
  logic [1:0]        entry_d;
  logic [STAT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, id_idx;
  logic             is_br, taken, mispred, upd;

  logic signed [DATA_W-1:0] rs_s;
  logic                     rs_neg, rs_zero, rs_eq_rt;

  // Only the word-index bits of the PCs address the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc[31:IDX_W+2], bus.if_pc[1:0],
                            bus.id_pc[31:IDX_W+2], bus.id_pc[1:0]};

  assign if_idx   = bus.if_pc[IDX_W+1:2];
  assign id_idx   = bus.id_pc[IDX_W+1:2];
  assign rs_s     = bus.rsv;
  assign rs_neg   = rs_s < 0;
  assign rs_zero  = bus.rsv == '0;
  assign rs_eq_rt = bus.rsv == bus.rtv;

  always_comb begin
    is_br = 1'b0;
    taken = 1'b0;
    unique case (bus.id_op)
      OP_BEQ:  begin is_br = 1'b1; taken = rs_eq_rt;            end
      OP_BNE:  begin is_br = 1'b1; taken = !rs_eq_rt;           end
      OP_BLEZ: begin is_br = 1'b1; taken = rs_neg || rs_zero;   end
      OP_BGTZ: begin is_br = 1'b1; taken = !rs_neg && !rs_zero; end
      OP_REGIMM: begin
        // Bit 4 of rt selects the linking variant; direction is unaffected.
        unique case (bus.id_rt)
          5'b00000, 5'b10000: begin is_br = 1'b1; taken = rs_neg;  end
          5'b00001, 5'b10001: begin is_br = 1'b1; taken = !rs_neg; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign upd     = bus.id_valid && is_br;
  assign mispred = upd && (taken != bus.id_pred_taken);

  // Saturating 2-bit counter step for the entry being resolved.
  always_comb begin
    entry_d = bht_q[id_idx];
    if (taken && bht_q[id_idx] != 2'b11)
      entry_d = bht_q[id_idx] + 2'b01;
    else if (!taken && bht_q[id_idx] != 2'b00)
      entry_d = bht_q[id_idx] - 2'b01;
  end

  assign branch_cnt_d  = (upd && !(&branch_cnt_q))    ? branch_cnt_q + 1'b1  : branch_cnt_q;
  assign mispred_cnt_d = (mispred && !(&mispred_cnt_q)) ? mispred_cnt_q + 1'b1 : mispred_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (upd) bht_q[id_idx] <= entry_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // Lookup reads the registered table, so a same-cycle update is not seen.
  assign bus.if_pred_taken = bht_q[if_idx][1];
  assign bus.is_branch     = is_br;
  assign bus.branch_taken  = taken;
  assign bus.mispredict    = mispred;
  assign bus.branch_cnt    = branch_cnt_q;
  assign bus.mispred_cnt   = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_bht_if #(.DATA_W(32), .STAT_W(32)) u_if  ();
  branch_resolve_bht_if #(.DATA_W(32), .STAT_W(4))  u_if4 ();

  branch_resolve_bht #(.DATA_W(32), .BHT_DEPTH(64), .STAT_W(32))
    u_dut  (.clk(clk), .rst(rst), .bus(u_if.slave));
  branch_resolve_bht #(.DATA_W(32), .BHT_DEPTH(64), .STAT_W(4))
    u_dut4 (.clk(clk), .rst(rst), .bus(u_if4.slave));

  // Narrow-statistics instance sees the same traffic.
  assign u_if4.if_pc         = u_if.if_pc;
  assign u_if4.id_valid      = u_if.id_valid;
  assign u_if4.id_pc         = u_if.id_pc;
  assign u_if4.id_op         = u_if.id_op;
  assign u_if4.id_rt         = u_if.id_rt;
  assign u_if4.rsv           = u_if.rsv;
  assign u_if4.rtv           = u_if.rtv;
  assign u_if4.id_pred_taken = u_if.id_pred_taken;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural reference model ----------------
  int     m_tbl [64];
  longint m_br  = 0;
  longint m_mis = 0;
  bit     m_ready = 0;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  // returns {is_branch, taken}
  function automatic logic [1:0] m_resolve(input logic [5:0] op, input logic [4:0] rt,
                                           input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (op)
      6'd4: return {1'b1, a == b};
      6'd5: return {1'b1, a != b};
      6'd6: return {1'b1, sa <= 0};
      6'd7: return {1'b1, sa > 0};
      6'd1: begin
        if (rt == 5'd0 || rt == 5'd16) return {1'b1, sa < 0};
        if (rt == 5'd1 || rt == 5'd17) return {1'b1, sa >= 0};
        return 2'b00;
      end
      default: return 2'b00;
    endcase
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clk) begin
    logic [1:0] r;
    int i;
    r = m_resolve(u_if.id_op, u_if.id_rt, u_if.rsv, u_if.rtv);
    i = m_idx(u_if.id_pc);
    m_ready <= 1;
    if (rst) begin
      for (int k = 0; k < 64; k++) m_tbl[k] <= 1;
      m_br  <= 0;
      m_mis <= 0;
    end else if (u_if.id_valid && r[1]) begin
      m_tbl[i] <= r[0] ? ((m_tbl[i] < 3) ? m_tbl[i] + 1 : 3)
                       : ((m_tbl[i] > 0) ? m_tbl[i] - 1 : 0);
      m_br <= m_br + 1;
      if (r[0] != u_if.id_pred_taken) m_mis <= m_mis + 1;
    end
  end

  // single compare process, away from the active edge
  always @(negedge clk) begin
    logic [1:0] r;
    logic mp;
    if (m_ready) begin
      r  = m_resolve(u_if.id_op, u_if.id_rt, u_if.rsv, u_if.rtv);
      mp = u_if.id_valid && r[1] && (r[0] != u_if.id_pred_taken);
      chk("m_pred",    u_if.if_pred_taken, (m_tbl[m_idx(u_if.if_pc)] >= 2) ? 1 : 0);
      chk("m_isbr",    u_if.is_branch,     r[1]);
      chk("m_taken",   u_if.branch_taken,  r[0]);
      chk("m_mispred", u_if.mispredict,    mp);
      chk("m_brcnt",   u_if.branch_cnt,    sat(m_br, 32));
      chk("m_miscnt",  u_if.mispred_cnt,   sat(m_mis, 32));
      chk("m_brcnt4",  u_if4.branch_cnt,   sat(m_br, 4));
      chk("m_miscnt4", u_if4.mispred_cnt,  sat(m_mis, 4));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drv(input bit v, input logic [31:0] pc, input logic [5:0] op,
                     input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                     input bit pred);
    u_if.id_valid = v; u_if.id_pc = pc; u_if.id_op = op; u_if.id_rt = rt;
    u_if.rsv = a; u_if.rtv = b; u_if.id_pred_taken = pred;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    u_if.if_pc = 32'h100;
    drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    rst = 1;
    nxt(); nxt();
    rst = 0;
    mid();
    chk("rst_pred", u_if.if_pred_taken, 0);
    chk("rst_brcnt", u_if.branch_cnt, 0);

    // BEQ taken, predicted not-taken
    nxt(); drv(1, 32'h100, 6'd4, 5'd0, 5, 5, 0);
    mid();
    chk("beq_taken", u_if.branch_taken, 1);
    chk("beq_mispred", u_if.mispredict, 1);
    chk("beq_pred_before", u_if.if_pred_taken, 0);
    nxt(); drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid();
    chk("beq_pred_after", u_if.if_pred_taken, 1);
    chk("beq_brcnt", u_if.branch_cnt, 1);
    chk("beq_miscnt", u_if.mispred_cnt, 1);

    // REGIMM decode
    nxt(); drv(1, 32'h300, 6'd1, 5'd1, 0, 0, 1);
    mid(); chk("bgez_zero", u_if.branch_taken, 1);
    nxt(); drv(1, 32'h300, 6'd1, 5'd0, 32'hFFFF_FFFF, 0, 1);
    mid(); chk("bltz_neg", u_if.branch_taken, 1);
    nxt(); drv(1, 32'h300, 6'd1, 5'd2, 32'hFFFF_FFFF, 0, 1);
    mid(); chk("regimm_bad_isbr", u_if.is_branch, 0);
    nxt(); drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid();
    chk("regimm_brcnt", u_if.branch_cnt, 3);
    chk("regimm_miscnt", u_if.mispred_cnt, 1);

    // BNE saturation at pc 0x204 (index 1)
    u_if.if_pc = 32'h204;
    for (int k = 0; k < 4; k++) begin
      nxt(); drv(1, 32'h204, 6'd5, 5'd0, 1, 2, 1);
      mid(); chk("bne_sat_pred", u_if.if_pred_taken, (k == 0) ? 0 : 1);
    end
    nxt(); drv(1, 32'h204, 6'd5, 5'd0, 7, 7, 1);
    mid(); chk("bne_nt_pred_cur", u_if.if_pred_taken, 1);
    nxt(); drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid(); chk("bne_nt_pred_after", u_if.if_pred_taken, 1);

    // same-cycle lookup/update, index 2
    u_if.if_pc = 32'h208;
    nxt(); drv(1, 32'h208, 6'd7, 5'd0, 3, 0, 0);
    mid(); chk("rbw_same", u_if.if_pred_taken, 0);
    nxt(); drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid(); chk("rbw_next", u_if.if_pred_taken, 1);

    // id_valid=0 does nothing
    u_if.if_pc = 32'h20C;
    nxt(); drv(0, 32'h20C, 6'd4, 5'd0, 1, 1, 0);
    nxt(); drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid(); chk("novalid_pred", u_if.if_pred_taken, 0);

    // reset with a simultaneous valid update
    u_if.if_pc = 32'h208;
    nxt(); rst = 1; drv(1, 32'h208, 6'd4, 5'd0, 1, 1, 0);
    nxt(); rst = 0; drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid();
    chk("rstupd_pred", u_if.if_pred_taken, 0);
    chk("rstupd_brcnt", u_if.branch_cnt, 0);
    chk("rstupd_miscnt", u_if.mispred_cnt, 0);

    // 17 branches -> 4-bit statistics saturate at 15
    for (int k = 0; k < 17; k++) begin
      nxt(); drv(1, 32'h400 + 4 * k, 6'd6, 5'd0, 0, 0, 0);
    end
    nxt(); drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid();
    chk("stat4_sat", u_if4.branch_cnt, 15);
    chk("stat32_17", u_if.branch_cnt, 17);
    chk("stat4_mis", u_if4.mispred_cnt, 15);

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      logic [5:0] op;
      logic [31:0] a, b;
      int sel;
      nxt();
      sel = $urandom_range(0, 9);
      case (sel)
        0: op = 6'd4; 1: op = 6'd5; 2: op = 6'd6; 3: op = 6'd7;
        4, 5: op = 6'd1;
        default: op = 6'($urandom);
      endcase
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed($urandom_range(0, 4)) - 2);
      b = ($urandom_range(0, 1) == 0) ? a : 32'($signed($urandom_range(0, 4)) - 2);
      rst = ($urandom_range(0, 199) == 0);
      u_if.if_pc = {$urandom_range(0, 3), 6'($urandom), 2'($urandom)};
      drv($urandom_range(0, 3) != 0,
          {$urandom_range(0, 3), 6'($urandom), 2'($urandom)},
          op, ($urandom_range(0, 1) == 0) ? 5'($urandom) : {$urandom_range(0, 1) == 1, 3'b000, 1'($urandom)},
          a, b, 1'($urandom));
    end
    nxt(); rst = 0; drv(0, 32'h0, 6'd0, 5'd0, 0, 0, 0);
    mid();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
